// File: rtl/video_src.sv
// video_src: parallel-video timing and test-pattern source with a free-running completed-frame counter.
// Latency: outputs registered one cycle behind the FSM; no backpressure, timing runs free once started.
module video_src #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [1:0]            pat_i,
    input  logic [CNT_WIDTH-1:0]  h_active_i,
    input  logic [CNT_WIDTH-1:0]  h_blank_i,
    input  logic [CNT_WIDTH-1:0]  v_active_i,
    input  logic [CNT_WIDTH-1:0]  v_blank_i,
    output logic [DATA_WIDTH-1:0] do_o,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic [15:0]           fr_cnt_o,
    output logic                  busy_o
);

    localparam int XW = CNT_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HBLANK = 2'd2,
        S_VBLANK = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0]           pat;
        logic [CNT_WIDTH-1:0] ha;
        logic [CNT_WIDTH-1:0] hb;
        logic [CNT_WIDTH-1:0] va;
        logic [CNT_WIDTH-1:0] vb;
    } cfg_t;

    state_t                state_q, state_d;
    cfg_t                  cfg_q, cfg_d, cfg_in;
    logic                  start_ok;
    logic [XW-1:0]         x_q, x_d;
    logic [XW-1:0]         h_last, hb_last, line_last;
    logic [CNT_WIDTH-1:0]  y_q, y_d;
    logic [CNT_WIDTH-1:0]  va_last, vb_last;
    logic [DATA_WIDTH-1:0] pix;
    logic [DATA_WIDTH-1:0] do_q, do_d;
    logic                  de_q, de_d, hs_q, hs_d, vs_q, vs_d, busy_q, busy_d;
    logic [15:0]           fr_q, fr_d;

    assign cfg_in    = '{pat: pat_i, ha: h_active_i, hb: h_blank_i, va: v_active_i, vb: v_blank_i};
    assign start_ok  = en_i && (h_active_i != '0) && (h_blank_i != '0)
                       && (v_active_i != '0) && (v_blank_i != '0);
    assign h_last    = {1'b0, cfg_q.ha} - XW'(1);
    assign hb_last   = {1'b0, cfg_q.hb} - XW'(1);
    assign line_last = {1'b0, cfg_q.ha} + {1'b0, cfg_q.hb} - XW'(1);
    assign va_last   = cfg_q.va - CNT_WIDTH'(1);
    assign vb_last   = cfg_q.vb - CNT_WIDTH'(1);

    // x_q is reused as the cycle counter in HBLANK and the in-line counter in VBLANK.
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                x_d = '0;
                y_d = '0;
                if (start_ok) begin
                    state_d = S_ACTIVE;
                    cfg_d   = cfg_in;
                end
            end
            S_ACTIVE: begin
                if (x_q == h_last) begin
                    state_d = S_HBLANK;
                    x_d     = '0;
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
            S_HBLANK: begin
                if (x_q == hb_last) begin
                    x_d = '0;
                    if (y_q == va_last) begin
                        state_d = S_VBLANK;
                        y_d     = '0;
                    end else begin
                        state_d = S_ACTIVE;
                        y_d     = y_q + CNT_WIDTH'(1);
                    end
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
            default: begin
                if (x_q == line_last) begin
                    x_d = '0;
                    if (y_q == vb_last) begin
                        y_d = '0;
                        if (start_ok) begin
                            state_d = S_ACTIVE;
                            cfg_d   = cfg_in;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        y_d = y_q + CNT_WIDTH'(1);
                    end
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
        endcase
    end

    always_comb begin
        pix = '0;
        case (cfg_q.pat)
            2'd0:    pix = DATA_WIDTH'(x_q);
            2'd1:    pix = DATA_WIDTH'(y_q);
            2'd2:    pix = {DATA_WIDTH{x_q[3] ^ y_q[3]}};
            default: pix = DATA_WIDTH'(x_q) + DATA_WIDTH'(y_q) + DATA_WIDTH'(fr_q);
        endcase
    end

    // Outputs follow the FSM by one cycle; the counter bumps on the first VBLANK cycle, where vs drops.
    always_comb begin
        do_d   = (state_q == S_ACTIVE) ? pix : '0;
        de_d   = (state_q == S_ACTIVE);
        hs_d   = (state_q != S_ACTIVE);
        vs_d   = (state_q == S_ACTIVE) || (state_q == S_HBLANK);
        busy_d = (state_q != S_IDLE);
        fr_d   = fr_q;
        if ((state_q == S_VBLANK) && (x_q == '0) && (y_q == '0)) begin
            fr_d = fr_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cfg_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            do_q    <= '0;
            de_q    <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b0;
            busy_q  <= 1'b0;
            fr_q    <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            x_q     <= x_d;
            y_q     <= y_d;
            do_q    <= do_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            busy_q  <= busy_d;
            fr_q    <= fr_d;
        end
    end

    assign do_o     = do_q;
    assign de_o     = de_q;
    assign hs_o     = hs_q;
    assign vs_o     = vs_q;
    assign busy_o   = busy_q;
    assign fr_cnt_o = fr_q;

endmodule

// File: tb/tb_video_src.sv
// Bench for video_src: directed timing/pattern vectors plus randomized traffic against a frame-level model.
module tb_video_src;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_i = 1'b0;
    logic [1:0]  pat_i = 2'd0;
    logic [11:0] h_active_i = 12'd4;
    logic [11:0] h_blank_i = 12'd2;
    logic [11:0] v_active_i = 12'd3;
    logic [11:0] v_blank_i = 12'd1;
    logic [7:0]  do_o;
    logic        de_o, hs_o, vs_o, busy_o;
    logic [15:0] fr_cnt_o;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    video_src #(.DATA_WIDTH(8), .CNT_WIDTH(12)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .pat_i(pat_i),
        .h_active_i(h_active_i), .h_blank_i(h_blank_i),
        .v_active_i(v_active_i), .v_blank_i(v_blank_i),
        .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
        .fr_cnt_o(fr_cnt_o), .busy_o(busy_o)
    );

    // Reference model: each started frame is expanded into its full list of output cycles.
    typedef struct packed {
        logic [7:0] d;
        logic       de, hs, vs, busy, finc;
    } orec_t;
    localparam orec_t IDLE_R = '{d: 8'd0, de: 1'b0, hs: 1'b1, vs: 1'b0, busy: 1'b0, finc: 1'b0};

    orec_t       mq[$];
    orec_t       cur = IDLE_R;
    logic [15:0] fr_m = 16'd0;

    function automatic logic [7:0] ref_pix(int p, int x, int y, int f);
        case (p)
            0:       return 8'(x);
            1:       return 8'(y);
            2:       return (((x / 8) + (y / 8)) % 2 == 1) ? 8'hFF : 8'h00;
            default: return 8'(x + y + f);
        endcase
    endfunction

    task automatic push_frame(int ha, int hb, int va, int vb, int p, int f);
        for (int y = 0; y < va; y++) begin
            for (int x = 0; x < ha; x++)
                mq.push_back('{d: ref_pix(p, x, y, f), de: 1'b1, hs: 1'b0, vs: 1'b1, busy: 1'b1, finc: 1'b0});
            for (int b = 0; b < hb; b++)
                mq.push_back('{d: 8'd0, de: 1'b0, hs: 1'b1, vs: 1'b1, busy: 1'b1, finc: 1'b0});
        end
        for (int i = 0; i < vb * (ha + hb); i++)
            mq.push_back('{d: 8'd0, de: 1'b0, hs: 1'b1, vs: 1'b0, busy: 1'b1, finc: (i == 0)});
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            fr_m = 16'd0;
            cur = IDLE_R;
        end else begin
            if (mq.size() > 0) begin
                cur = mq.pop_front();
                if (cur.finc) fr_m = fr_m + 16'd1;
            end else begin
                cur = IDLE_R;
            end
            if (mq.size() == 0 && en_i && h_active_i != 0 && h_blank_i != 0
                && v_active_i != 0 && v_blank_i != 0)
                push_frame(int'(h_active_i), int'(h_blank_i), int'(v_active_i),
                           int'(v_blank_i), int'(pat_i), int'(fr_m));
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            total++;
            if (do_o !== cur.d || de_o !== cur.de || hs_o !== cur.hs || vs_o !== cur.vs
                || busy_o !== cur.busy || fr_cnt_o !== fr_m) begin
                bad++;
                $display("FAIL model t=%0t got do=%0h de=%0b hs=%0b vs=%0b busy=%0b fr=%0d exp do=%0h de=%0b hs=%0b vs=%0b busy=%0b fr=%0d",
                         $time, do_o, de_o, hs_o, vs_o, busy_o, fr_cnt_o,
                         cur.d, cur.de, cur.hs, cur.vs, cur.busy, fr_m);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        en_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        int ha, hb, va, vb, pat, en_cyc, chg_cyc, chg_ha;
        int e_busy, e_de, e_vs, e_fr, e_per;
    } vec_t;
    typedef struct {
        int v, f, idx, val;
    } probe_t;

    vec_t       vt[5];
    probe_t     pt[19];
    logic [7:0] pix[4][512];
    int         pcnt[4];

    task automatic run_vec(input vec_t v, input int vi);
        int  c = 0, nbusy = 0, nde = 0, nvs = 0, per = 0, first_rise = -1, f;
        bit  seen = 0, done = 0;
        logic prev_vs = 1'b0;
        do_reset();
        for (int a = 0; a < 4; a++) begin
            pcnt[a] = 0;
            for (int b = 0; b < 512; b++) pix[a][b] = 8'h5A;
        end
        h_active_i = 12'(v.ha);
        h_blank_i  = 12'(v.hb);
        v_active_i = 12'(v.va);
        v_blank_i  = 12'(v.vb);
        pat_i      = 2'(v.pat);
        en_i       = 1'b1;
        while (!done && c < 3000) begin
            @(posedge clk);
            c++;
            #1;
            if (c >= v.en_cyc) en_i = 1'b0;
            if (c == v.chg_cyc) h_active_i = 12'(v.chg_ha);
            @(negedge clk);
            if (busy_o) begin
                seen = 1;
                nbusy++;
            end else if (seen) begin
                done = 1;
            end
            if (de_o) begin
                nde++;
                f = (fr_cnt_o > 3) ? 3 : int'(fr_cnt_o);
                if (pcnt[f] < 512) pix[f][pcnt[f]] = do_o;
                pcnt[f]++;
            end
            if (vs_o) nvs++;
            if (vs_o && !prev_vs) begin
                if (first_rise < 0) first_rise = c;
                else if (per == 0) per = c - first_rise;
            end
            prev_vs = vs_o;
        end
        chk($sformatf("v%0d_finished", vi), int'(done), 1);
        chk($sformatf("v%0d_busy_cycles", vi), nbusy, v.e_busy);
        chk($sformatf("v%0d_de_cycles", vi), nde, v.e_de);
        chk($sformatf("v%0d_vs_cycles", vi), nvs, v.e_vs);
        chk($sformatf("v%0d_fr_cnt", vi), int'(fr_cnt_o), v.e_fr);
        chk($sformatf("v%0d_frame_period", vi), per, v.e_per);
        for (int k = 0; k < 19; k++)
            if (pt[k].v == vi)
                chk($sformatf("v%0d_pix_f%0d_i%0d", vi, pt[k].f, pt[k].idx),
                    int'(pix[pt[k].f][pt[k].idx]), pt[k].val);
    endtask

    function automatic logic [11:0] rcfg(int hi);
        if ($urandom_range(0, 11) == 0) return 12'd0;
        return 12'($urandom_range(1, hi));
    endfunction

    initial begin
        int nb, nd, cnt;
        bit found;

        // ha hb va vb pat en_cyc chg_cyc chg_ha | busy de vs fr period
        vt[0] = '{4, 2, 3, 1, 0, 1, 0, 0, 24, 12, 18, 1, 0};
        vt[1] = '{4, 2, 3, 1, 1, 60, 0, 0, 72, 36, 54, 3, 24};
        vt[2] = '{16, 1, 16, 1, 2, 1, 0, 0, 289, 256, 272, 1, 0};
        vt[3] = '{4, 2, 3, 1, 3, 60, 0, 0, 72, 36, 54, 3, 24};
        vt[4] = '{4, 2, 3, 1, 0, 30, 5, 8, 64, 36, 48, 2, 24};
        pt[0]  = '{0, 0, 0, 0};   pt[1]  = '{0, 0, 3, 3};
        pt[2]  = '{0, 0, 7, 3};   pt[3]  = '{0, 0, 8, 0};
        pt[4]  = '{1, 0, 0, 0};   pt[5]  = '{1, 0, 5, 1};
        pt[6]  = '{1, 0, 11, 2};  pt[7]  = '{1, 2, 4, 1};
        pt[8]  = '{2, 0, 119, 0}; pt[9]  = '{2, 0, 8, 255};
        pt[10] = '{2, 0, 136, 0}; pt[11] = '{2, 0, 128, 255};
        pt[12] = '{3, 2, 0, 2};   pt[13] = '{3, 2, 7, 6};
        pt[14] = '{3, 1, 11, 6};  pt[15] = '{4, 0, 4, 0};
        pt[16] = '{4, 1, 7, 7};   pt[17] = '{4, 1, 8, 0};
        pt[18] = '{4, 0, 3, 3};

        @(posedge clk);
        @(negedge clk);
        chk_on = 1'b1;
        chk("rst_do", int'(do_o), 0);
        chk("rst_de", int'(de_o), 0);
        chk("rst_hs", int'(hs_o), 1);
        chk("rst_vs", int'(vs_o), 0);
        chk("rst_fr", int'(fr_cnt_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vt[i], i);

        // Start latency: en sampled at edge N, first pixel visible after edge N+1.
        do_reset();
        h_active_i = 12'd4; h_blank_i = 12'd2; v_active_i = 12'd3; v_blank_i = 12'd1;
        pat_i = 2'd0;
        en_i = 1'b1;
        @(posedge clk);
        #1;
        en_i = 1'b0;
        @(negedge clk);
        chk("lat_n_de", int'(de_o), 0);
        chk("lat_n_busy", int'(busy_o), 0);
        @(negedge clk);
        chk("lat_n1_de", int'(de_o), 1);
        chk("lat_n1_busy", int'(busy_o), 1);
        chk("lat_n1_vs", int'(vs_o), 1);
        chk("lat_n1_hs", int'(hs_o), 0);
        repeat (40) @(posedge clk);

        // Zero active width never starts.
        do_reset();
        h_active_i = 12'd0;
        en_i = 1'b1;
        nb = 0;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            nb += int'(busy_o);
            nd += int'(de_o);
        end
        chk("zero_ha_busy", nb, 0);
        chk("zero_ha_de", nd, 0);
        en_i = 1'b0;
        h_active_i = 12'd4;

        // Reset at x=2 of line 1, then no resumed partial frame.
        do_reset();
        en_i = 1'b1;
        @(posedge clk);
        #1;
        en_i = 1'b0;
        cnt = 0;
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (de_o) cnt++;
            if (cnt == 7) found = 1;
        end
        chk("mid_rst_reached", int'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_de", int'(de_o), 0);
        chk("mid_rst_hs", int'(hs_o), 1);
        chk("mid_rst_vs", int'(vs_o), 0);
        chk("mid_rst_fr", int'(fr_cnt_o), 0);
        chk("mid_rst_busy", int'(busy_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        nb = 0;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            nb += int'(busy_o);
            nd += int'(de_o);
        end
        chk("post_rst_busy", nb, 0);
        chk("post_rst_de", nd, 0);

        // Randomized traffic: config churn, en toggling, occasional resets.
        do_reset();
        repeat (3000) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) en_i = ~en_i;
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 4))
                    0: h_active_i = rcfg(12);
                    1: h_blank_i = rcfg(3);
                    2: v_active_i = rcfg(5);
                    3: v_blank_i = rcfg(2);
                    default: pat_i = 2'($urandom_range(0, 3));
                endcase
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        en_i = 1'b0;
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("drain_idle", int'(busy_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
